instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 27 ++
 rtl/instr_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the instruction source/datapath and the sequencer.
// The slave modport is the sequencer side; the master modport is the source/datapath side.
interface instr_sequencer_if;
  logic       Run;
  logic [8:0] DIN;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       IRin;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       AddSub;
  logic       Done;
  logic       Busy;
  logic [7:0] InstrCount;

  modport slave (
    input  Run, DIN,
    output Rin, Rout, DINout, IRin, Ain, Gin, Gout, AddSub, Done, Busy, InstrCount
  );

  modport master (
    output Run, DIN,
    input  Rin, Rout, DINout, IRin, Ain, Gin, Gout, AddSub, Done, Busy, InstrCount
  );
endinterface

// File: rtl/instr_sequencer.sv
// Four-state control sequencer for a simple 8-register processor (MV, MVI, ADD, SUB, no-op).
// Instruction format III XXX YYY; the control outputs are decoded combinationally from state and IR.
module instr_sequencer (
  input  logic               Clock,
  input  logic               Resetn,
  instr_sequencer_if.slave   seq_if
);
  localparam int unsigned IrW  = 9;
  localparam int unsigned RegN = 8;
  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IrW-1:0]  ir_q, ir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op;
  logic [RegN-1:0] x_oh, y_oh;

  assign op   = ir_q[8:6];
  assign x_oh = RegN'(1) << ir_q[5:3];
  assign y_oh = RegN'(1) << ir_q[2:0];

  // State, instruction register and completed-instruction counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d       = T0;
    ir_d          = ir_q;
    seq_if.Rin    = '0;
    seq_if.Rout   = '0;
    seq_if.DINout = 1'b0;
    seq_if.IRin   = 1'b0;
    seq_if.Ain    = 1'b0;
    seq_if.Gin    = 1'b0;
    seq_if.Gout   = 1'b0;
    seq_if.AddSub = 1'b0;
    seq_if.Done   = 1'b0;

    case (state_q)
      T0: begin
        seq_if.IRin = seq_if.Run;
        if (seq_if.Run) begin
          ir_d    = seq_if.DIN;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          3'b000: begin
            seq_if.Rout = y_oh;
            seq_if.Rin  = x_oh;
            seq_if.Done = 1'b1;
          end
          3'b001: begin
            seq_if.DINout = 1'b1;
            seq_if.Rin    = x_oh;
            seq_if.Done   = 1'b1;
          end
          3'b010, 3'b011: begin
            seq_if.Rout = x_oh;
            seq_if.Ain  = 1'b1;
            state_d     = T2;
          end
          default: seq_if.Done = 1'b1;
        endcase
      end
      T2: begin
        seq_if.Rout   = y_oh;
        seq_if.Gin    = 1'b1;
        seq_if.AddSub = (op == 3'b011);
        state_d       = T3;
      end
      T3: begin
        seq_if.Gout = 1'b1;
        seq_if.Rin  = x_oh;
        seq_if.Done = 1'b1;
      end
      default: state_d = T0;
    endcase
  end

  // Counter wraps naturally at 8 bits
  assign cnt_d             = cnt_q + CntW'(seq_if.Done);
  assign seq_if.Busy       = (state_q != T0);
  assign seq_if.InstrCount = cnt_q;

endmodule
